// File: rtl/song_player.sv
// song_player: autonomous note sequencer that walks a song ROM and drives note/octave for the buzzer.
// Ports: clk, rst_n (async active-low); start/stop/pause/loop_en controls;
//        rom_addr/rom_data synchronous ROM (1-cycle latency);
//        note/octave_up/octave_down buzzer interface; busy, done, note_idx status.
module song_player #(
  parameter int TICKS_PER_BEAT = 25000000,
  parameter int GAP_TICKS      = 2500000,
  parameter int ADDR_W         = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic [3:0]        note,
  output logic              octave_up,
  output logic              octave_down,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);
  localparam int MAXT = TICKS_PER_BEAT > GAP_TICKS ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int TW   = MAXT > 1 ? $clog2(MAXT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LATCH, S_PLAY, S_GAP, S_END, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        beat_q, beat_d, beats_q, beats_d;
  logic [ADDR_W-1:0] addr_q, addr_d, idx_q, idx_d;
  logic [3:0]        note_q, note_d;
  logic              up_q, up_d, dn_q, dn_d, played_q, played_d;

  logic [2:0] rom_beats;
  logic       frozen, play_tick_last, gap_tick_last, beat_last, last_addr;

  assign rom_beats      = rom_data[8:6];
  // pause freezes every busy state in place; it is meaningless in IDLE
  assign frozen         = pause && state_q != S_IDLE;
  assign play_tick_last = tick_q == TW'(TICKS_PER_BEAT - 1);
  assign gap_tick_last  = tick_q == TW'(GAP_TICKS - 1);
  assign beat_last      = beat_q == beats_q - 3'd1;
  assign last_addr      = &addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) state_d = S_IDLE;
    else if (!frozen) begin
      case (state_q)
        S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
        S_FETCH: state_d = S_WAIT;
        S_WAIT:  state_d = S_LATCH;
        S_LATCH: state_d = rom_beats == 3'd0 ? S_END : S_PLAY;
        S_PLAY:  state_d = play_tick_last && beat_last ? S_GAP : S_PLAY;
        S_GAP:   state_d = gap_tick_last ? (last_addr ? S_END : S_FETCH) : S_GAP;
        S_END:   state_d = loop_en && played_q ? S_FETCH : S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tick_d   = tick_q;
    beat_d   = beat_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    note_d   = note_q;
    up_d     = up_q;
    dn_d     = dn_q;
    played_d = played_q;
    if (stop) begin
      tick_d   = '0;
      beat_d   = '0;
      addr_d   = '0;
      idx_d    = '0;
      note_d   = '0;
      up_d     = 1'b0;
      dn_d     = 1'b0;
      played_d = 1'b0;
    end else if (!frozen) begin
      case (state_q)
        S_IDLE: begin
          addr_d   = '0;
          played_d = 1'b0;
        end
        S_LATCH: begin
          tick_d  = '0;
          beat_d  = '0;
          beats_d = rom_beats;
          if (rom_beats != 3'd0) begin
            idx_d    = addr_q;
            played_d = 1'b1;
            note_d   = rom_data[3] ? 4'd0 : rom_data[3:0];
            up_d     = rom_data[5:4] == 2'b01;
            dn_d     = rom_data[5:4] == 2'b10;
          end
        end
        S_PLAY: begin
          tick_d = play_tick_last ? '0 : tick_q + 1'b1;
          beat_d = play_tick_last ? beat_q + 3'd1 : beat_q;
          if (play_tick_last && beat_last) begin
            note_d = '0;
            up_d   = 1'b0;
            dn_d   = 1'b0;
          end
        end
        S_GAP: begin
          tick_d = gap_tick_last ? '0 : tick_q + 1'b1;
          addr_d = gap_tick_last && !last_addr ? addr_q + 1'b1 : addr_q;
        end
        S_END: begin
          // a pass that played nothing (empty song) must not restart
          if (loop_en && played_q) begin
            addr_d   = '0;
            played_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= '0;
      beat_q   <= '0;
      beats_q  <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      note_q   <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      played_q <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      beat_q   <= beat_d;
      beats_q  <= beats_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      played_q <= played_d;
    end
  end

  always_comb begin
    note        = pause ? 4'd0 : note_q;
    octave_up   = up_q && !pause;
    octave_down = dn_q && !pause;
    busy        = state_q != S_IDLE;
    done        = state_q == S_DONE;
    rom_addr    = addr_q;
    note_idx    = idx_q;
  end
endmodule
